// File: rtl/vending_ctrl.sv
// Multi-slot vending controller: run-time price/inventory tables, saturating
// cash credit with coin rejection, card payment, and greedy Q/D/N change.
module vending_ctrl #(
   parameter int unsigned NUM_SLOTS  = 8,
   parameter int unsigned PRICE_W    = 9,
   parameter int unsigned INV_W      = 4,
   parameter int unsigned MAX_CREDIT = 500,
   localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int unsigned CFG_W = (PRICE_W > INV_W) ? PRICE_W : INV_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sel_valid,
   input  logic [IDX_W-1:0]   sel_index,
   input  logic               nickel,
   input  logic               dime,
   input  logic               quarter,
   input  logic               dollar,
   input  logic               card_valid,
   input  logic [PRICE_W-1:0] card_balance,
   input  logic               cancel,
   input  logic               price_wr,
   input  logic               inv_wr,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [CFG_W-1:0]   cfg_data,
   output logic               dispensed,
   output logic [IDX_W-1:0]   dispensed_index,
   output logic [PRICE_W-1:0] card_debit,
   output logic               card_ok,
   output logic               card_decline,
   output logic               out_of_stock,
   output logic               coin_reject,
   output logic               coin_out_q,
   output logic               coin_out_d,
   output logic               coin_out_n,
   output logic [PRICE_W-1:0] balance,
   output logic               busy
);

   // Wide enough that balance plus a full cycle of coins never overflows.
   localparam int unsigned SUM_W = PRICE_W + 8;

   typedef enum logic [1:0] {IDLE, PAY, DISPENSE, CHANGE} state_t;

   state_t state, state_n;

   logic [PRICE_W-1:0] price_tab [NUM_SLOTS];
   logic [INV_W-1:0]   inv_tab   [NUM_SLOTS];

   logic [IDX_W-1:0]   sel_idx_q, sel_idx_n;
   logic [PRICE_W-1:0] sel_price_q, sel_price_n;
   logic [PRICE_W-1:0] balance_n, eff, card_debit_n;
   logic [IDX_W-1:0]   dispensed_index_n;
   logic [SUM_W-1:0]   coin_sum, credit_sum;
   logic               any_coin, fits, sel_ok, cfg_ok;
   logic               dispensed_n, card_ok_n, card_decline_n, out_of_stock_n, coin_reject_n;
   logic               coin_q_n, coin_d_n, coin_n_n;
   logic               price_we, inv_we, inv_dec;

   // Next-state, next-output and table-write decode.
   always_comb begin
      state_n           = state;
      balance_n         = balance;
      sel_idx_n         = sel_idx_q;
      sel_price_n       = sel_price_q;
      dispensed_index_n = dispensed_index;
      card_debit_n      = card_debit;
      dispensed_n       = 1'b0;
      card_ok_n         = 1'b0;
      card_decline_n    = 1'b0;
      out_of_stock_n    = 1'b0;
      coin_reject_n     = 1'b0;
      coin_q_n          = 1'b0;
      coin_d_n          = 1'b0;
      coin_n_n          = 1'b0;
      price_we          = 1'b0;
      inv_we            = 1'b0;
      inv_dec           = 1'b0;

      any_coin = nickel | dime | quarter | dollar;
      coin_sum = '0;
      if (nickel)  coin_sum = coin_sum + SUM_W'(5);
      if (dime)    coin_sum = coin_sum + SUM_W'(10);
      if (quarter) coin_sum = coin_sum + SUM_W'(25);
      if (dollar)  coin_sum = coin_sum + SUM_W'(100);
      credit_sum = SUM_W'(balance) + coin_sum;
      fits       = (credit_sum <= SUM_W'(MAX_CREDIT));
      eff        = balance;
      sel_ok     = (32'(sel_index) < NUM_SLOTS) && (inv_tab[sel_index] != '0);
      cfg_ok     = (32'(cfg_idx) < NUM_SLOTS);

      unique case (state)
         IDLE, PAY: begin
            if (state == IDLE) begin
               price_we = price_wr && cfg_ok;
               inv_we   = inv_wr && cfg_ok;
            end
            if (cancel) begin
               coin_reject_n = any_coin;
               state_n       = (balance == '0) ? IDLE : CHANGE;
            end else begin
               if (any_coin) begin
                  if (fits) begin
                     eff       = credit_sum[PRICE_W-1:0];
                     balance_n = eff;
                  end else begin
                     coin_reject_n = 1'b1;
                  end
               end
               if (state == IDLE) begin
                  if (!(price_wr || inv_wr) && sel_valid) begin
                     if (sel_ok) begin
                        sel_idx_n   = sel_index;
                        sel_price_n = price_tab[sel_index];
                        state_n     = PAY;
                     end else begin
                        out_of_stock_n = 1'b1;
                     end
                  end
               end else if (eff >= sel_price_q) begin
                  balance_n         = eff - sel_price_q;
                  dispensed_n       = 1'b1;
                  dispensed_index_n = sel_idx_q;
                  state_n           = DISPENSE;
               end else if (card_valid) begin
                  if (card_balance >= sel_price_q) begin
                     card_ok_n         = 1'b1;
                     card_debit_n      = sel_price_q;
                     dispensed_n       = 1'b1;
                     dispensed_index_n = sel_idx_q;
                     state_n           = DISPENSE;
                  end else begin
                     card_decline_n = 1'b1;
                  end
               end
            end
         end
         DISPENSE: begin
            coin_reject_n = any_coin;
            inv_dec       = 1'b1;
            state_n       = (balance != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            coin_reject_n = any_coin;
            if (balance >= PRICE_W'(25)) begin
               coin_q_n  = 1'b1;
               balance_n = balance - PRICE_W'(25);
            end else if (balance >= PRICE_W'(10)) begin
               coin_d_n  = 1'b1;
               balance_n = balance - PRICE_W'(10);
            end else if (balance >= PRICE_W'(5)) begin
               coin_n_n  = 1'b1;
               balance_n = balance - PRICE_W'(5);
            end else begin
               balance_n = '0;
            end
            if (balance_n == '0) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // Registered outputs and latched selection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         balance         <= '0;
         sel_idx_q       <= '0;
         sel_price_q     <= '0;
         dispensed_index <= '0;
         card_debit      <= '0;
         dispensed       <= 1'b0;
         card_ok         <= 1'b0;
         card_decline    <= 1'b0;
         out_of_stock    <= 1'b0;
         coin_reject     <= 1'b0;
         coin_out_q      <= 1'b0;
         coin_out_d      <= 1'b0;
         coin_out_n      <= 1'b0;
         busy            <= 1'b0;
      end else begin
         balance         <= balance_n;
         sel_idx_q       <= sel_idx_n;
         sel_price_q     <= sel_price_n;
         dispensed_index <= dispensed_index_n;
         card_debit      <= card_debit_n;
         dispensed       <= dispensed_n;
         card_ok         <= card_ok_n;
         card_decline    <= card_decline_n;
         out_of_stock    <= out_of_stock_n;
         coin_reject     <= coin_reject_n;
         coin_out_q      <= coin_q_n;
         coin_out_d      <= coin_d_n;
         coin_out_n      <= coin_n_n;
         busy            <= (state_n == DISPENSE) || (state_n == CHANGE);
      end
   end

   // Price and inventory tables; the vend decrement never collides with a
   // config write because writes are only honoured in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            price_tab[i] <= '0;
            inv_tab[i]   <= '0;
         end
      end else begin
         if (price_we) price_tab[cfg_idx] <= cfg_data[PRICE_W-1:0];
         if (inv_we)   inv_tab[cfg_idx]   <= cfg_data[INV_W-1:0];
         if (inv_dec)  inv_tab[sel_idx_q] <= inv_tab[sel_idx_q] - INV_W'(1);
      end
   end

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl: table of per-cycle vectors plus
// hand-written credit-ceiling/refund and reset-during-change sequences.
module tb_vending_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sel_valid, nickel, dime, quarter, dollar, card_valid, cancel, price_wr, inv_wr;
   logic [2:0] sel_index, cfg_idx, dispensed_index;
   logic [8:0] card_balance, cfg_data, card_debit, balance;
   logic       dispensed, card_ok, card_decline, out_of_stock, coin_reject;
   logic       coin_out_q, coin_out_d, coin_out_n, busy;

   int passed = 0;
   int total  = 0;

   typedef logic [29:0] obs_t;

   typedef struct packed {
      logic       sel;
      logic [2:0] sidx;
      logic [3:0] coins;   // {dollar, quarter, dime, nickel}
      logic       cv;
      logic [8:0] cb;
      logic       pw;
      logic       iw;
      logic [2:0] cidx;
      logic [8:0] cd;
      obs_t       ex;
   } vec_t;

   vec_t vq[$];

   vending_ctrl #(.NUM_SLOTS(8), .PRICE_W(9), .INV_W(4), .MAX_CREDIT(500)) dut (
      .clk(clk), .reset_n(reset_n), .sel_valid(sel_valid), .sel_index(sel_index),
      .nickel(nickel), .dime(dime), .quarter(quarter), .dollar(dollar),
      .card_valid(card_valid), .card_balance(card_balance), .cancel(cancel),
      .price_wr(price_wr), .inv_wr(inv_wr), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
      .dispensed(dispensed), .dispensed_index(dispensed_index), .card_debit(card_debit),
      .card_ok(card_ok), .card_decline(card_decline), .out_of_stock(out_of_stock),
      .coin_reject(coin_reject), .coin_out_q(coin_out_q), .coin_out_d(coin_out_d),
      .coin_out_n(coin_out_n), .balance(balance), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   function automatic obs_t e(input logic disp, input logic [2:0] idx, input logic ok,
                              input logic dec, input logic oos, input logic rej,
                              input logic [2:0] qdn, input logic bsy,
                              input logic [8:0] bal, input logic [8:0] dbt);
      return {disp, idx, ok, dec, oos, rej, qdn, bsy, bal, dbt};
   endfunction

   function automatic obs_t obs();
      return {dispensed, dispensed_index, card_ok, card_decline, out_of_stock, coin_reject,
              coin_out_q, coin_out_d, coin_out_n, busy, balance, card_debit};
   endfunction

   task automatic check(input string name, input obs_t ex);
      obs_t got;
      got = obs();
      total++;
      if (got === ex) passed++;
      else $display("FAIL %s: got %h expected %h (disp,idx,ok,dec,oos,rej,qdn,busy,bal,debit)",
                    name, got, ex);
   endtask

   task automatic clear_inputs();
      sel_valid = 0; sel_index = 0; {dollar, quarter, dime, nickel} = 4'b0;
      card_valid = 0; card_balance = 0; cancel = 0;
      price_wr = 0; inv_wr = 0; cfg_idx = 0; cfg_data = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic sel, input logic [2:0] sidx, input logic [3:0] c,
                       input logic cv, input logic [8:0] cb, input logic pw, input logic iw,
                       input logic [2:0] cidx, input logic [8:0] cd, input obs_t ex);
      vec_t v;
      v.sel = sel; v.sidx = sidx; v.coins = c; v.cv = cv; v.cb = cb;
      v.pw = pw; v.iw = iw; v.cidx = cidx; v.cd = cd; v.ex = ex;
      vq.push_back(v);
   endtask

   task automatic t_idle(input obs_t ex);                          push(0,0,0,0,0,0,0,0,0,ex);  endtask
   task automatic t_sel(input logic [2:0] i, input obs_t ex);      push(1,i,0,0,0,0,0,0,0,ex);  endtask
   task automatic t_coin(input logic [3:0] c, input obs_t ex);     push(0,0,c,0,0,0,0,0,0,ex);  endtask
   task automatic t_card(input logic [3:0] c, input logic [8:0] cb, input obs_t ex);
      push(0,0,c,1,cb,0,0,0,0,ex);
   endtask
   task automatic t_wp(input logic [2:0] i, input logic [8:0] d, input obs_t ex); push(0,0,0,0,0,1,0,i,d,ex); endtask
   task automatic t_wi(input logic [2:0] i, input logic [8:0] d, input obs_t ex); push(0,0,0,0,0,0,1,i,d,ex); endtask

   localparam logic [3:0] N = 4'b0001, D = 4'b0010, Q = 4'b0100, DL = 4'b1000;

   initial begin
      clear_inputs();
      reset_n = 0;
      step(); step();
      check("reset_state", '0);
      @(negedge clk);
      reset_n = 1;
      step();
      check("after_release", '0);

      // 65c slot paid with three quarters, one dime back; inventory 2 -> 1 -> 0.
      t_wp(3, 65,   e(0,0,0,0,0,0,3'b000,0,0,0));
      t_wi(3, 2,    e(0,0,0,0,0,0,3'b000,0,0,0));
      t_sel(3,      e(0,0,0,0,0,0,3'b000,0,0,0));
      t_coin(Q,     e(0,0,0,0,0,0,3'b000,0,25,0));
      t_coin(Q,     e(0,0,0,0,0,0,3'b000,0,50,0));
      t_coin(Q,     e(1,3,0,0,0,0,3'b000,1,10,0));
      t_idle(       e(0,3,0,0,0,0,3'b000,1,10,0));
      t_idle(       e(0,3,0,0,0,0,3'b010,0,0,0));
      t_idle(       e(0,3,0,0,0,0,3'b000,0,0,0));
      t_sel(3,      e(0,3,0,0,0,0,3'b000,0,0,0));
      t_card(0, 65, e(1,3,1,0,0,0,3'b000,1,0,65));
      t_idle(       e(0,3,0,0,0,0,3'b000,0,0,65));
      t_sel(3,      e(0,3,0,0,1,0,3'b000,0,0,65));
      // Never-stocked slot and card ignored in IDLE.
      t_sel(5,      e(0,3,0,0,1,0,3'b000,0,0,65));
      t_card(0, 300,e(0,3,0,0,0,0,3'b000,0,0,65));
      // Card decline then card accept; cash credit refunded afterwards.
      t_wp(1, 150,  e(0,3,0,0,0,0,3'b000,0,0,65));
      t_wi(1, 3,    e(0,3,0,0,0,0,3'b000,0,0,65));
      t_sel(1,      e(0,3,0,0,0,0,3'b000,0,0,65));
      t_coin(DL,    e(0,3,0,0,0,0,3'b000,0,100,65));
      t_card(0, 100,e(0,3,0,1,0,0,3'b000,0,100,65));
      t_card(0, 200,e(1,1,1,0,0,0,3'b000,1,100,150));
      t_idle(       e(0,1,0,0,0,0,3'b000,1,100,150));
      t_idle(       e(0,1,0,0,0,0,3'b100,1,75,150));
      t_idle(       e(0,1,0,0,0,0,3'b100,1,50,150));
      t_idle(       e(0,1,0,0,0,0,3'b100,1,25,150));
      t_idle(       e(0,1,0,0,0,0,3'b100,0,0,150));
      // 33c price, 35c in one cycle: 2c residue forfeited; coin in DISPENSE rejected.
      t_wp(2, 33,   e(0,1,0,0,0,0,3'b000,0,0,150));
      t_wi(2, 1,    e(0,1,0,0,0,0,3'b000,0,0,150));
      t_sel(2,      e(0,1,0,0,0,0,3'b000,0,0,150));
      t_coin(Q|D,   e(1,2,0,0,0,0,3'b000,1,2,150));
      t_coin(N,     e(0,2,0,0,0,1,3'b000,1,2,150));
      t_idle(       e(0,2,0,0,0,0,3'b000,0,0,150));
      // Zero price vends straight from PAY.
      t_wi(4, 1,    e(0,2,0,0,0,0,3'b000,0,0,150));
      t_sel(4,      e(0,2,0,0,0,0,3'b000,0,0,150));
      t_idle(       e(1,4,0,0,0,0,3'b000,1,0,150));
      t_idle(       e(0,4,0,0,0,0,3'b000,0,0,150));
      // Enough cash and a card in the same cycle: cash wins.
      t_sel(1,      e(0,4,0,0,0,0,3'b000,0,0,150));
      t_coin(DL,    e(0,4,0,0,0,0,3'b000,0,100,150));
      t_card(DL,300,e(1,1,0,0,0,0,3'b000,1,50,150));
      t_idle(       e(0,1,0,0,0,0,3'b000,1,50,150));
      t_idle(       e(0,1,0,0,0,0,3'b100,1,25,150));
      t_idle(       e(0,1,0,0,0,0,3'b100,0,0,150));

      foreach (vq[k]) begin
         sel_valid = vq[k].sel; sel_index = vq[k].sidx;
         {dollar, quarter, dime, nickel} = vq[k].coins;
         card_valid = vq[k].cv; card_balance = vq[k].cb;
         price_wr = vq[k].pw; inv_wr = vq[k].iw; cfg_idx = vq[k].cidx; cfg_data = vq[k].cd;
         step();
         clear_inputs();
         check($sformatf("vec%0d", k), vq[k].ex);
      end

      // Credit ceiling: exactly 500 accepted, next nickel rejected, then full refund.
      for (int i = 1; i <= 5; i++) begin
         dollar = 1; step(); clear_inputs();
         check($sformatf("fill_dollar%0d", i), e(0,1,0,0,0,0,3'b000,0,9'(100*i),150));
      end
      nickel = 1; step(); clear_inputs();
      check("ceiling_reject", e(0,1,0,0,0,1,3'b000,0,500,150));
      cancel = 1; step(); clear_inputs();
      check("cancel_500", e(0,1,0,0,0,0,3'b000,1,500,150));
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("refund_q%0d", i),
               e(0,1,0,0,0,0,3'b100,(i < 19),9'(500 - 25*(i+1)),150));
      end
      step();
      check("refund_done", e(0,1,0,0,0,0,3'b000,0,0,150));

      // Reset while in CHANGE with 40c: everything clears and no coins follow.
      for (int i = 1; i <= 4; i++) begin
         dime = 1; step(); clear_inputs();
         check($sformatf("load_dime%0d", i), e(0,1,0,0,0,0,3'b000,0,9'(10*i),150));
      end
      cancel = 1; nickel = 1; step(); clear_inputs();
      check("cancel_40_rej", e(0,1,0,0,0,1,3'b000,1,40,150));
      reset_n = 0;
      #1;
      check("async_reset", '0);
      step(); step();
      @(negedge clk);
      reset_n = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("post_reset%0d", i), '0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
Parametrised vending-machine controller and next generation of the single-product cash/card vender. It adds a configurable slot count, per-slot price and inventory tables writable at run time, and saturating credit with coin rejection. It returns exact change as a serial stream of coin pulses, greedy quarter/dime/nickel. It sits between the coin acceptor, card reader and keypad front-ends and the dispenser/coin-hopper drivers.

Parameters:
NUM_SLOTS, 8, number of product slots (index 0..NUM_SLOTS-1)
PRICE_W, 9, width of prices, credit balance and card balance (cents)
INV_W, 4, width of per-slot inventory count
MAX_CREDIT, 500, cash balance ceiling in cents; must be < 2**PRICE_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
sel_valid  in  1  product selection strobe
sel_index  in  $clog2(NUM_SLOTS)  selected slot
nickel, dime, quarter, dollar  in  1 each  coin-insert pulses (5/10/25/100 cents)
card_valid  in  1  card presented strobe
card_balance  in  PRICE_W  card funds, sampled with card_valid
cancel  in  1  refund request
price_wr, inv_wr  in  1 each  table write strobes (honoured only in IDLE)
cfg_idx  in  $clog2(NUM_SLOTS)  table write slot
cfg_data  in  max(PRICE_W,INV_W)  price or inventory value (low bits used)
dispensed  out  1  one-cycle vend pulse
dispensed_index  out  $clog2(NUM_SLOTS)  slot vended, held until next vend
card_debit  out  PRICE_W  amount to charge, valid with card_ok
card_ok, card_decline, out_of_stock, coin_reject  out  1 each  one-cycle status pulses
coin_out_q, coin_out_d, coin_out_n  out  1 each  change-coin pulses, at most one high per cycle
balance  out  PRICE_W  current cash credit
busy  out  1  high in DISPENSE and CHANGE

Behaviour:
- Reset (async assert, sync release): state=IDLE; balance=0; all pulse outputs 0; dispensed_index=0; card_debit=0; price and inventory tables cleared to 0.
- States are IDLE, PAY, DISPENSE and CHANGE. All outputs are registered, one cycle after the causing input.
- Coins are accepted in IDLE and PAY. The sum of all coin bits high in the same cycle is added as one amount.
  - If balance+sum > MAX_CREDIT, the whole cycle's coins are rejected: coin_reject pulses and balance is unchanged.
  - In DISPENSE and CHANGE, any coin bit causes coin_reject.
- IDLE:
  - Table writes apply here; cfg_idx >= NUM_SLOTS is ignored. A write takes priority over sel_valid in the same cycle.
  - sel_valid with index < NUM_SLOTS and inventory != 0: latch index and price, go to PAY.
  - Inventory == 0 or index out of range: out_of_stock pulses, stay in IDLE.
- PAY (evaluated each cycle using the balance including this cycle's accepted coins):
  - If balance >= price: balance -= price, go to DISPENSE.
  - Else if card_valid and card_balance >= price: card_ok pulses, card_debit=price, go to DISPENSE; cash balance is untouched.
  - Else if card_valid: card_decline pulses, stay in PAY.
  - Cash check has priority over card.
- DISPENSE: lasts one cycle.
  - dispensed pulses, dispensed_index=latched index, inventory[index] -= 1 (never wraps, since it was nonzero).
  - Next state is CHANGE if balance != 0, else IDLE.
- CANCEL:
  - cancel in IDLE or PAY goes to CHANGE; same-cycle coins are rejected and card_valid is ignored.
  - In PAY, cancel has priority over the funds checks. With balance == 0, cancel goes straight to IDLE.
  - cancel is ignored in DISPENSE and CHANGE.
- CHANGE: one coin per cycle.
  - If balance >= 25: coin_out_q, balance -= 25.
  - Else if balance >= 10: coin_out_d, balance -= 10.
  - Else if balance >= 5: coin_out_n, balance -= 5.
  - Else (residue 1-4 cents from a non-multiple-of-5 price): residue is forfeited, balance=0, no coin.
  - Go to IDLE on the cycle balance becomes 0.
- Reset mid-CHANGE: remaining credit is lost and the state returns to IDLE.
- Arithmetic is unsigned PRICE_W. A price of 0 vends immediately from PAY.

Test Plan:
- Reset, write price[3]=65 and inv[3]=2, select 3, then quarter×3 -> DISPENSE one cycle after the third quarter; dispensed=1, dispensed_index=3, then coin_out_d once; balance 0; inv[3]=1.
- Select slot 5 with inv[5]=0 -> out_of_stock pulse, state stays IDLE, balance unchanged.
- price[1]=150, select 1, dollar, card_valid with card_balance=100 -> card_decline. Then card_balance=200 -> card_ok, card_debit=150, dispensed. Cash refund follows: coin_out_q×4.
- Insert dollar×5 (500), then nickel -> coin_reject, balance stays 500. Cancel -> coin_out_q×20, then IDLE.
- price[2]=33, select 2, quarter+dime in the same cycle (35) -> vend; balance 2 forfeited; no coin pulses; back to IDLE.
- Assert reset_n=0 mid-CHANGE with balance 40 -> all outputs 0 immediately, IDLE; no further coin pulses after release.
